// File: rtl/fetch_if.sv
// Bus bundle between the fetch unit and its memory / register-file environment.
// start is taken only while busy=0; memData is valid only in a cycle with memRead=1 and memReady=1.
interface fetch_if;
  logic        start;
  logic [1:0]  operandCount;
  logic [15:0] PC;
  logic [7:0]  memData;
  logic        memReady;
  logic [15:0] memAddr;
  logic        memRead;
  logic [7:0]  dataIn;
  logic [2:0]  regSelect;
  logic        load;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, operandCount, PC, memData, memReady,
    output memAddr, memRead, dataIn, regSelect, load, opcode, operand, busy, done, error
  );

  modport slave (
    output start, operandCount, PC, memData, memReady,
    input  memAddr, memRead, dataIn, regSelect, load, opcode, operand, busy, done, error
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: reads opcode plus 0-2 operand bytes from PC, then writes the advanced PC back.
// Optional per-byte read timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WRLO = 3'd2,
    WRHI = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] ptr;
  logic [15:0] ptr_inc;
  logic [1:0]  count;
  logic [1:0]  idx;

  logic [15:0] mem_addr_q;
  logic        mem_read_q;
  logic [7:0]  data_in_q;
  logic [2:0]  reg_select_q;
  logic        load_q;
  logic [7:0]  opcode_q;
  logic [15:0] operand_q;
  logic        busy_q;
  logic        done_q;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
  logic        error_q;
`endif

  // 16-bit add wraps FFFF -> 0000 naturally.
  assign ptr_inc = ptr + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= 16'd0;
      count        <= 2'd0;
      idx          <= 2'd0;
      mem_addr_q   <= 16'd0;
      mem_read_q   <= 1'b0;
      data_in_q    <= 8'd0;
      reg_select_q <= 3'd0;
      load_q       <= 1'b0;
      opcode_q     <= 8'd0;
      operand_q    <= 16'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt     <= 16'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= READ;
            ptr        <= bus.PC;
            count      <= (bus.operandCount == 2'd3) ? 2'd2 : bus.operandCount;
            idx        <= 2'd0;
            operand_q  <= 16'd0;
            mem_read_q <= 1'b1;
            mem_addr_q <= bus.PC;
            busy_q     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt   <= 16'd0;
`endif
          end
        end
        READ: begin
          if (bus.memReady) begin
            case (idx)
              2'd0:    opcode_q        <= bus.memData;
              2'd1:    operand_q[7:0]  <= bus.memData;
              default: operand_q[15:8] <= bus.memData;
            endcase
            ptr <= ptr_inc;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= 16'd0;
`endif
            if (idx == count) begin
              // Last byte: the PC low write uses the already-advanced pointer.
              state        <= WRLO;
              mem_read_q   <= 1'b0;
              mem_addr_q   <= 16'd0;
              load_q       <= 1'b1;
              reg_select_q <= 3'd4;
              data_in_q    <= ptr_inc[7:0];
            end else begin
              idx        <= idx + 2'd1;
              mem_addr_q <= ptr_inc;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            state      <= ERR;
            mem_read_q <= 1'b0;
            mem_addr_q <= 16'd0;
            error_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        WRLO: begin
          state        <= WRHI;
          reg_select_q <= 3'd5;
          data_in_q    <= ptr[15:8];
        end
        WRHI: begin
          state        <= DONE;
          load_q       <= 1'b0;
          reg_select_q <= 3'd0;
          data_in_q    <= 8'd0;
          done_q       <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        ERR: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memAddr   = mem_addr_q;
  assign bus.memRead   = mem_read_q;
  assign bus.dataIn    = data_in_q;
  assign bus.regSelect = reg_select_q;
  assign bus.load      = load_q;
  assign bus.opcode    = opcode_q;
  assign bus.operand   = operand_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif
  assign dbg_state     = state;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15; max wait cycles per memory byte (used only with FETCH_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  fetch request; sampled only in IDLE.
REQ-005 operandCount  input  2  operand bytes following opcode: 0, 1, 2; value 3 treated as 2.
REQ-006 PC  input  16  current program counter from register file.
REQ-007 memData  input  8  read data from memory.
REQ-008 memReady  input  1  memData valid this cycle.
REQ-009 memAddr  output  16  read address.
REQ-010 memRead  output  1  read strobe.
REQ-011 dataIn  output  8  byte driven to register file write port.
REQ-012 regSelect  output  3  register file target; 4 = PC low, 5 = PC high.
REQ-013 load  output  1  register file write enable.
REQ-014 opcode  output  8  captured opcode byte.
REQ-015 operand  output  16  captured operands; byte 1 in [7:0], byte 2 in [15:8].
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 error  output  1  one-cycle pulse on timeout abort.

Function
REQ-019 States: IDLE, READ, WRLO, WRHI, DONE, ERR.
REQ-020 IDLE: start=1 latches PC into internal ptr, latches operandCount into internal count, clears operand to 0, and moves to READ.
REQ-021 READ: memRead=1, memAddr=ptr; on memReady=1, capture memData (byte 0 -> opcode, byte 1 -> operand[7:0], byte 2 -> operand[15:8]) and increment ptr.
REQ-022 ptr increment wraps 16'hFFFF -> 16'h0000; no carry out.
REQ-023 READ exits to WRLO after 1+count bytes are captured; otherwise stays in READ.
REQ-024 WRLO: load=1, regSelect=4, dataIn=ptr[7:0] for exactly one cycle, then WRHI.
REQ-025 WRHI: load=1, regSelect=5, dataIn=ptr[15:8] for exactly one cycle, then DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 Outside WRLO/WRHI: load=0, regSelect=0, dataIn=0. Outside READ: memRead=0, memAddr=0.
REQ-028 Zero-wait latency: start at edge 0 -> done high in cycle 3+(1+count).
REQ-029 start while busy is ignored; no queuing.
REQ-030 memReady outside READ is ignored.
REQ-031 opcode and operand hold their values until the next accepted start.

Reset
REQ-032 reset=1 at a clock edge forces IDLE, ptr=0, count=0, opcode=0, operand=0, and all outputs to 0; this applies from any state.
REQ-033 Reset during READ/WRLO/WRHI aborts the fetch; no further load pulse is issued, including for an unwritten PC high byte.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN defined: a per-byte wait counter clears on READ entry and after each captured byte; reaching TIMEOUT_CYCLES without memReady moves to ERR, with no PC write.
REQ-035 ERR: error=1 for one cycle, then IDLE; opcode and operand keep the bytes captured before the timeout.
REQ-036 Macro FETCH_TIMEOUT_EN undefined: READ waits indefinitely, ERR is unreachable, and error is tied to 0.

Verification
REQ-037 reset=1 for 2 cycles -> all outputs 0, busy=0.
REQ-038 PC=16'h0200, operandCount=0, memReady=1, memData=8'hEA -> opcode=8'hEA; load with regSelect=4/dataIn=8'h01, then regSelect=5/dataIn=8'h02; done pulses in cycle 4.
REQ-039 PC=16'hC000, operandCount=2, bytes 8'h4C, 8'h34, 8'h12 with 2 wait cycles each -> operand=16'h1234; PC written as 16'hC003.
REQ-040 PC=16'hFFFF, operandCount=1 -> reads addresses FFFF then 0000; PC written as 16'h0001.
REQ-041 Assert reset during WRHI after the WRLO write -> no regSelect=5 load occurs; next cycle is IDLE with all outputs 0.
REQ-042 FETCH_TIMEOUT_EN defined, memReady held at 0 -> error pulses after 15 READ cycles; load never asserted; done stays 0.
